// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one word per frame from a registered-read FIFO and
// serialises it as start, data (LSB first), optional parity and stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [BW-1:0]         baud;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  parity_bit;
    logic                  tx_next;
    logic                  bit_end;

    assign bit_end   = (baud == BAUD_LAST);
    assign fifo_read = (state == FETCH);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && bit_cnt == DATA_LAST)
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end && bit_cnt == STOP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the level the next state will drive.
    always_comb begin
        shift_next = shift;
        if (state == LOAD)
            shift_next = fifo_read_data;
        else if (state == DATA && bit_end)
            shift_next = shift >> 1;
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            tx         <= tx_next;
            frame_done <= (state == STOP) && (state_next == IDLE);
            if (state == LOAD)
                parity_bit <= (^fifo_read_data) ^ (PARITY_ODD != 0);
            if (state inside {START, DATA, PARITY, STOP})
                baud <= bit_end ? '0 : baud + 1'b1;
            else
                baud <= '0;
            // Cleared on every state entry; counts data bits, then stop bits.
            if (state_next != state)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitter configurations drain one shared word
// stream; a line monitor per instance checks each frame against a bit model.
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] words [0:1023];
    int         wp = 0;
    int         cyc = 0;
    logic       rst_edge = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Line level of frame bit i: start, data LSB first, parity, stop bits.
    function automatic logic exp_bit(input logic [7:0] w, input int i,
                                     input int pen, input int pod);
        if (i == 0) return 1'b0;
        if (i <= 8) return w[i-1];
        if (i == 9 && pen != 0) return (^w) ^ (pod != 0);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CPB = (g == 2) ? 3 : 4;
        localparam int STB = (g == 0) ? 1 : 2;
        localparam int PEN = (g == 0) ? 0 : 1;
        localparam int POD = (g == 2) ? 1 : 0;
        localparam int FB  = 1 + 8 + PEN + STB;

        logic       tx;
        logic       busy;
        logic       fifo_read;
        logic       frame_done;
        logic [7:0] rd_data = 8'h00;
        logic       empty;
        int         rp = 0;
        int         pops = 0;
        logic [7:0] q[$];
        int         mode = 0;
        int         k = 0;
        int         bad = 0;
        int         expect_start = -1;
        logic [7:0] cur = 8'h00;

        assign empty = (rp == wp);

        fifo_uart_tx #(
            .DATA_WIDTH(8),
            .CLKS_PER_BIT(CPB),
            .STOP_BITS(STB),
            .PARITY_EN(PEN),
            .PARITY_ODD(POD)
        ) dut (
            .clk(clk),
            .reset(reset),
            .enable(enable),
            .fifo_empty(empty),
            .fifo_read(fifo_read),
            .fifo_read_data(rd_data),
            .tx(tx),
            .busy(busy),
            .frame_done(frame_done)
        );

        // FIFO model: data valid only the cycle after a pop.
        always @(posedge clk) begin
            if (fifo_read === 1'b1) begin
                chk($sformatf("u%0d_pop_when_empty", g), int'(empty), 0);
                chk($sformatf("u%0d_pop_time", g), cyc, expect_start - 2);
                if (!empty) begin
                    rd_data <= words[rp];
                    q.push_back(words[rp]);
                    rp <= rp + 1;
                end
                pops <= pops + 1;
            end else begin
                rd_data <= 8'($urandom);
            end
        end

        always @(negedge clk) begin
            logic idle_now;
            idle_now = 1'b0;
            if (rst_edge) begin
                chk($sformatf("u%0d_reset_outputs", g),
                    int'({tx, busy, fifo_read, frame_done}), 8);
                mode = 0;
                q.delete();
                expect_start = -1;
                idle_now = 1'b1;
            end else begin
                if (mode == 2) begin
                    chk($sformatf("u%0d_frame_done", g),
                        int'({frame_done, busy, tx}), 5);
                    mode = 0;
                    idle_now = 1'b1;
                end else if (mode == 0) begin
                    if (tx == 1'b0) begin
                        chk($sformatf("u%0d_start_time", g), cyc, expect_start);
                        chk($sformatf("u%0d_words_in_flight", g), q.size(), 1);
                        cur = (q.size() > 0) ? q.pop_front() : 8'h00;
                        mode = 1;
                        k = 0;
                        bad = 0;
                        expect_start = -1;
                    end else begin
                        chk($sformatf("u%0d_stray_done", g), int'(frame_done), 0);
                        if (expect_start >= 0 && cyc >= expect_start) begin
                            chk($sformatf("u%0d_start_late", g), int'(tx), 0);
                            expect_start = -1;
                        end else begin
                            idle_now = (expect_start < 0);
                        end
                    end
                end
                if (mode == 1) begin
                    if (tx !== exp_bit(cur, k / CPB, PEN, POD)) bad++;
                    if (busy !== 1'b1) bad++;
                    if (k % CPB == CPB - 1) begin
                        chk($sformatf("u%0d_word%02h_bit%0d_bad_samples",
                                      g, cur, k / CPB), bad, 0);
                        bad = 0;
                    end
                    k++;
                    if (k == FB * CPB) mode = 2;
                end
            end
            // Idle with work available: start bit lands three cycles later.
            if (idle_now && enable && !empty && !reset)
                expect_start = cyc + 3;
        end
    end

    task automatic push(input logic [7:0] w);
        words[wp] = w;
        wp = wp + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, p1, p2;
        reset  = 1'b1;
        enable = 1'b1;
        push(8'hA5);
        step(2);
        chk("u0_no_pop_in_reset", u[0].pops, 0);
        chk("u1_no_pop_in_reset", u[1].pops, 0);
        chk("u2_no_pop_in_reset", u[2].pops, 0);
        reset = 1'b0;
        step(70);

        push(8'h00);
        push(8'hFF);
        step(130);

        push(8'h07);
        step(70);

        enable = 1'b0;
        repeat (3) push(8'($urandom));
        p0 = u[0].pops;
        p1 = u[1].pops;
        p2 = u[2].pops;
        step(100);
        chk("u0_no_pop_disabled", u[0].pops, p0);
        chk("u1_no_pop_disabled", u[1].pops, p1);
        chk("u2_no_pop_disabled", u[2].pops, p2);

        enable = 1'b1;
        step(15);
        enable = 1'b0;
        step(100);
        chk("u0_one_pop_after_drop", u[0].pops, p0 + 1);
        chk("u1_one_pop_after_drop", u[1].pops, p1 + 1);
        chk("u2_one_pop_after_drop", u[2].pops, p2 + 1);

        enable = 1'b1;
        step(19);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(80);
        chk("u0_drained_after_reset", u[0].rp, wp);
        chk("u1_drained_after_reset", u[1].rp, wp);
        chk("u2_drained_after_reset", u[2].rp, wp);
        chk("u0_pops_after_reset", u[0].pops, p0 + 3);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 24) == 0 && wp < 1000)
                push(8'($urandom));
            enable = ($urandom_range(0, 7) != 0);
            step(1);
        end

        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (u[0].rp == wp && u[1].rp == wp && u[2].rp == wp &&
                u[0].mode == 0 && u[1].mode == 0 && u[2].mode == 0 &&
                u[0].expect_start < 0 && u[1].expect_start < 0 &&
                u[2].expect_start < 0)
                break;
            step(1);
        end
        step(5);
        chk("u0_final_drain", u[0].rp, wp);
        chk("u1_final_drain", u[1].rp, wp);
        chk("u2_final_drain", u[2].rp, wp);
        chk("u0_final_idle", u[0].mode, 0);
        chk("u1_final_idle", u[1].mode, 0);
        chk("u2_final_idle", u[2].mode, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
